// File: rtl/phase_error_tdc_5bit.sv
// Counter-based phase/frequency detector: measures clk cycles between rising
// edges of ref_in and fb_in, reports sign-magnitude error and a lock flag.

module phase_error_tdc_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [STAGES:0] chain;
  logic            hist;

  assign chain[0] = d;

  for (genvar i = 0; i < STAGES; i++) begin : g_sync
    always_ff @(posedge clk) begin
      if (reset) chain[i+1] <= 1'b0;
      else       chain[i+1] <= chain[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b0;
    else       hist <= chain[STAGES];
  end

  assign rise = chain[STAGES] & ~hist;
endmodule

module phase_error_tdc_5bit #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_COUNT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ref_in,
  input  logic       fb_in,
  output logic [4:0] error,
  output logic       error_sign,
  output logic       error_valid,
  output logic       lock
);
  localparam int         NUM_LANES = 2;
  localparam logic [4:0] CNT_MAX   = 5'd31;
  localparam logic [4:0] TOL       = 5'(LOCK_TOL);
  localparam logic [7:0] LOCK_MAX  = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

  // lane 0 = reference, lane 1 = feedback
  logic [NUM_LANES-1:0] lane_in, lane_rise;
  logic                 ref_rise, fb_rise;

  assign lane_in  = {fb_in, ref_in};
  assign ref_rise = lane_rise[0];
  assign fb_rise  = lane_rise[1];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    phase_error_tdc_edge #(.STAGES(SYNC_STAGES)) u_edge (
      .clk   (clk),
      .reset (reset),
      .d     (lane_in[l]),
      .rise  (lane_rise[l])
    );
  end

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n, cnt_inc;
  logic       pub, pub_sign;
  logic [4:0] pub_mag;
  logic [7:0] lock_cnt, lock_cnt_inc;

  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pub      = 1'b0;
    pub_mag  = '0;
    pub_sign = 1'b0;
    case (state)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          pub = 1'b1;
        end else if (ref_rise) begin
          state_n = REF_LEAD;
          cnt_n   = 5'd1;
        end else if (fb_rise) begin
          state_n = FB_LEAD;
          cnt_n   = 5'd1;
        end
      end
      REF_LEAD: begin
        if (fb_rise) begin
          // a coincident ref edge is dropped, measurement restarts from IDLE
          pub     = 1'b1;
          pub_mag = cnt;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (ref_rise) begin
          pub     = 1'b1;
          pub_mag = CNT_MAX;
          cnt_n   = 5'd1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      FB_LEAD: begin
        if (ref_rise) begin
          pub      = 1'b1;
          pub_mag  = cnt;
          pub_sign = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end else if (fb_rise) begin
          pub      = 1'b1;
          pub_mag  = CNT_MAX;
          pub_sign = 1'b1;
          cnt_n    = 5'd1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error       <= '0;
      error_sign  <= 1'b0;
      error_valid <= 1'b0;
    end else begin
      error_valid <= pub;
      if (pub) begin
        error      <= pub_mag;
        error_sign <= pub_sign;
      end
    end
  end

  assign lock_cnt_inc = (lock_cnt >= LOCK_MAX) ? LOCK_MAX : lock_cnt + 8'd1;

  // lock tracks a run of small errors; any large error or slip breaks it
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (pub) begin
      if (pub_mag <= TOL) begin
        lock_cnt <= lock_cnt_inc;
        lock     <= (lock_cnt_inc == LOCK_MAX);
      end else begin
        lock_cnt <= '0;
        lock     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_phase_error_tdc_5bit.sv
// Scoreboard bench for phase_error_tdc_5bit: expected updates are queued when
// the lagging edge is driven and compared when error_valid pulses.

module tb_phase_error_tdc_5bit;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ref_in = 1'b0;
  logic       fb_in = 1'b0;
  logic [4:0] error;
  logic       error_sign, error_valid, lock;

  phase_error_tdc_5bit #(.SYNC_STAGES(SYNC), .LOCK_TOL(1), .LOCK_COUNT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ref_in      (ref_in),
    .fb_in       (fb_in),
    .error       (error),
    .error_sign  (error_sign),
    .error_valid (error_valid),
    .lock        (lock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] err;
    logic       sign;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  int   lc_m = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // reference lock model: run of magnitudes <= 1, saturating at 8
  task automatic push_exp(input int mag, input bit sgn);
    exp_t e;
    if (mag <= 1) lc_m = (lc_m >= 8) ? 8 : lc_m + 1;
    else          lc_m = 0;
    e.err  = 5'(mag);
    e.sign = sgn;
    e.lock = (lc_m == 8);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (error_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: error=%0d sign=%0d, no update expected", error, error_sign);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (error !== e.err) begin
          n_fail++;
          $display("FAIL error_mag: got %0d, expected %0d", error, e.err);
        end
        n_checks++;
        if (error_sign !== e.sign) begin
          n_fail++;
          $display("FAIL error_sign: got %0d, expected %0d", error_sign, e.sign);
        end
        n_checks++;
        if (lock !== e.lock) begin
          n_fail++;
          $display("FAIL lock_on_valid: got %0d, expected %0d", lock, e.lock);
        end
      end
    end
  end

  // Drive leading edge, lagging edge k cycles later (k=0: coincident), then
  // wait (bounded) for the scoreboard to drain and the inputs to settle low.
  task automatic measure(input bit ref_leads, input int k);
    @(negedge clk);
    if (k == 0) begin
      ref_in = 1'b1;
      fb_in  = 1'b1;
      push_exp(0, 1'b0);
    end else begin
      if (ref_leads) ref_in = 1'b1; else fb_in = 1'b1;
      repeat (k) @(negedge clk);
      if (ref_leads) fb_in = 1'b1; else ref_in = 1'b1;
      push_exp((k > 31) ? 31 : k, !ref_leads);
    end
    repeat (3) @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ref_in = 1'b0;
    fb_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lc_m = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({error, error_sign, error_valid, lock} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000000", {error, error_sign, error_valid, lock});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (error_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_valid: got %0d, expected 0", error_valid);
    end
  endtask

  task automatic test_ref_lead();
    measure(1'b1, 5);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL ref_lead_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_fb_lead();
    measure(1'b0, 3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL fb_lead_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({error, error_sign, error_valid} !== {5'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_value: got err=%0d sign=%0d vld=%0d, expected 3/1/0", error, error_sign, error_valid);
    end
  endtask

  task automatic test_simultaneous();
    measure(1'b1, 0);
    measure(1'b1, 2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL simultaneous_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_saturation();
    measure(1'b1, 40);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL saturation_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_slip();
    @(negedge clk);
    ref_in = 1'b1;
    repeat (2) @(negedge clk);
    ref_in = 1'b0;
    repeat (8) @(negedge clk);
    ref_in = 1'b1;
    push_exp(31, 1'b0);
    repeat (4) @(negedge clk);
    fb_in = 1'b1;
    push_exp(4, 1'b0);
    repeat (3) @(negedge clk);
    ref_in = 1'b0;
    fb_in = 1'b0;
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    repeat (SYNC + 2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL slip_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 8; i++) measure(i[0], 1);
    n_checks++;
    if (lock !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_after_8: got %0d, expected 1", lock);
    end
    measure(1'b1, 2);
    n_checks++;
    if (lock !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drop: got %0d, expected 0", lock);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ref_in = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    reset = 1'b1;
    ref_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    lc_m = 0;
    n_checks++;
    if ({error, error_sign, error_valid, lock} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b, expected 00000000", {error, error_sign, error_valid, lock});
    end
    repeat (6) @(negedge clk);
    measure(1'b0, 2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_ref_lead();
    test_fb_lead();
    test_simultaneous();
    test_saturation();
    test_slip();
    test_lock();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
